// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
//   NOP_INSTR        : the all-zero word (sll $0,$0,0), used when IF/ID is flushed
//   DEFAULT_RESET_PC : default value loaded into the PC on reset
//   redirect_src_e   : which source, if any, redirects the PC this cycle
package mips_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    RS_NONE   = 2'd0,
    RS_BRANCH = 2'd1,
    RS_JREG   = 2'd2,
    RS_JUMP   = 2'd3
  } redirect_src_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection for the fetch stage.
// Ports:
//   pc_i             current PC
//   ifid_pcplus4_i   PC+4 of the instruction in ID (supplies jump bits [31:28])
//   branch_taken_i   resolved taken branch from EX (highest priority)
//   branch_target_i  branch target byte address
//   jreg_taken_i     jr in ID
//   jreg_target_i    rs value for jr
//   jump_taken_i     j/jal in ID (lowest priority)
//   jump_index_i     instr[25:0] of the jump
//   pc_plus4_o       pc_i + 4 (wraps modulo 2^32)
//   next_pc_o        aligned redirect target, or pc_plus4_o when no redirect
//   redirect_src_o   which source won the priority select
//   misalign_flag_o  redirect taken with a raw target whose bits [1:0] != 0
module fetch_next_pc
  import mips_pkg::*;
(
  input  logic [31:0]   pc_i,
  input  logic [31:0]   ifid_pcplus4_i,
  input  logic          branch_taken_i,
  input  logic [31:0]   branch_target_i,
  input  logic          jreg_taken_i,
  input  logic [31:0]   jreg_target_i,
  input  logic          jump_taken_i,
  input  logic [25:0]   jump_index_i,
  output logic [31:0]   pc_plus4_o,
  output logic [31:0]   next_pc_o,
  output redirect_src_e redirect_src_o,
  output logic          misalign_flag_o
);

  logic [31:0] jump_target;
  logic [31:0] raw_target;

  assign pc_plus4_o  = pc_i + 32'd4;
  assign jump_target = {ifid_pcplus4_i[31:28], jump_index_i, 2'b00};

  // A branch in EX is older than the jump/jr in ID, so it wins.
  always_comb begin
    redirect_src_o = RS_NONE;
    raw_target     = pc_plus4_o;
    if (branch_taken_i) begin
      redirect_src_o = RS_BRANCH;
      raw_target     = branch_target_i;
    end else if (jreg_taken_i) begin
      redirect_src_o = RS_JREG;
      raw_target     = jreg_target_i;
    end else if (jump_taken_i) begin
      redirect_src_o = RS_JUMP;
      raw_target     = jump_target;
    end
  end

  // The sequential path is always word aligned, so only a redirect can misalign.
  assign misalign_flag_o = (redirect_src_o != RS_NONE) && (raw_target[1:0] != 2'b00);
  assign next_pc_o       = {raw_target[31:2], 2'b00};

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID pipeline
// register, sticky misaligned-redirect flag and two event counters.
// Ports:
//   Clk, Rst_n          clock, asynchronous active-low reset
//   Stall               hold PC and IF/ID this cycle (overridden by a redirect)
//   BranchTaken/Target  taken branch resolved in EX
//   JumpTaken/JumpIndex j/jal decoded in ID
//   JRegTaken/Target    jr decoded in ID
//   InstrAddr           instruction-memory address (= PC)
//   InstrData           combinational instruction read of InstrAddr
//   IfId_Instr/PCPlus4/Valid  IF/ID register contents
//   AddrErr             sticky: some redirect target was misaligned
//   FetchCount          valid instructions loaded into IF/ID
//   RedirectCount       accepted redirects
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [31:0]      BranchTarget,
  input  logic             JumpTaken,
  input  logic [25:0]      JumpIndex,
  input  logic             JRegTaken,
  input  logic [31:0]      JRegTarget,
  output logic [31:0]      InstrAddr,
  input  logic [31:0]      InstrData,
  output logic [31:0]      IfId_Instr,
  output logic [31:0]      IfId_PCPlus4,
  output logic             IfId_Valid,
  output logic             AddrErr,
  output logic [CNT_W-1:0] FetchCount,
  output logic [CNT_W-1:0] RedirectCount
);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ifid_instr_q, ifid_instr_d;
  logic [31:0]      ifid_pcplus4_q, ifid_pcplus4_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic             addr_err_q, addr_err_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

  logic [31:0]      pc_plus4;
  logic [31:0]      next_pc;
  redirect_src_e    redirect_src;
  logic             misalign_flag;
  logic             redirect;

  fetch_next_pc u_next_pc (
    .pc_i            (pc_q),
    .ifid_pcplus4_i  (ifid_pcplus4_q),
    .branch_taken_i  (BranchTaken),
    .branch_target_i (BranchTarget),
    .jreg_taken_i    (JRegTaken),
    .jreg_target_i   (JRegTarget),
    .jump_taken_i    (JumpTaken),
    .jump_index_i    (JumpIndex),
    .pc_plus4_o      (pc_plus4),
    .next_pc_o       (next_pc),
    .redirect_src_o  (redirect_src),
    .misalign_flag_o (misalign_flag)
  );

  assign redirect = (redirect_src != RS_NONE);

  // Precedence: redirect, then stall, then normal sequential fetch.
  always_comb begin
    pc_d           = pc_q;
    ifid_instr_d   = ifid_instr_q;
    ifid_pcplus4_d = ifid_pcplus4_q;
    ifid_valid_d   = ifid_valid_q;
    addr_err_d     = addr_err_q;
    fetch_cnt_d    = fetch_cnt_q;
    redir_cnt_d    = redir_cnt_q;
    if (redirect) begin
      // The word in IF is on the wrong path; squash it instead of loading it.
      pc_d           = next_pc;
      ifid_instr_d   = NOP_INSTR;
      ifid_pcplus4_d = 32'h0;
      ifid_valid_d   = 1'b0;
      addr_err_d     = addr_err_q | misalign_flag;
      redir_cnt_d    = redir_cnt_q + 1'b1;
    end else if (!Stall) begin
      pc_d           = pc_plus4;
      ifid_instr_d   = InstrData;
      ifid_pcplus4_d = pc_plus4;
      ifid_valid_d   = 1'b1;
      fetch_cnt_d    = fetch_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc_q           <= RESET_PC;
      ifid_instr_q   <= NOP_INSTR;
      ifid_pcplus4_q <= 32'h0;
      ifid_valid_q   <= 1'b0;
      addr_err_q     <= 1'b0;
      fetch_cnt_q    <= '0;
      redir_cnt_q    <= '0;
    end else begin
      pc_q           <= pc_d;
      ifid_instr_q   <= ifid_instr_d;
      ifid_pcplus4_q <= ifid_pcplus4_d;
      ifid_valid_q   <= ifid_valid_d;
      addr_err_q     <= addr_err_d;
      fetch_cnt_q    <= fetch_cnt_d;
      redir_cnt_q    <= redir_cnt_d;
    end
  end

  assign InstrAddr     = pc_q;
  assign IfId_Instr    = ifid_instr_q;
  assign IfId_PCPlus4  = ifid_pcplus4_q;
  assign IfId_Valid    = ifid_valid_q;
  assign AddrErr       = addr_err_q;
  assign FetchCount    = fetch_cnt_q;
  assign RedirectCount = redir_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Counters are built 4 bits wide here so
// their modulo wrap can be reached in a few cycles.
module tb_fetch_stage;

  localparam int CNT_W = 4;

  logic             Clk;
  logic             Rst_n;
  logic             Stall;
  logic             BranchTaken;
  logic [31:0]      BranchTarget;
  logic             JumpTaken;
  logic [25:0]      JumpIndex;
  logic             JRegTaken;
  logic [31:0]      JRegTarget;
  logic [31:0]      InstrAddr;
  logic [31:0]      InstrData;
  logic [31:0]      IfId_Instr;
  logic [31:0]      IfId_PCPlus4;
  logic             IfId_Valid;
  logic             AddrErr;
  logic [CNT_W-1:0] FetchCount;
  logic [CNT_W-1:0] RedirectCount;

  int n_checks = 0;
  int n_errors = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .Stall         (Stall),
    .BranchTaken   (BranchTaken),
    .BranchTarget  (BranchTarget),
    .JumpTaken     (JumpTaken),
    .JumpIndex     (JumpIndex),
    .JRegTaken     (JRegTaken),
    .JRegTarget    (JRegTarget),
    .InstrAddr     (InstrAddr),
    .InstrData     (InstrData),
    .IfId_Instr    (IfId_Instr),
    .IfId_PCPlus4  (IfId_PCPlus4),
    .IfId_Valid    (IfId_Valid),
    .AddrErr       (AddrErr),
    .FetchCount    (FetchCount),
    .RedirectCount (RedirectCount)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Instruction memory: word 0 is addi $t0,$0,5; every other word is
  // {8'hAC, addr[23:0]} so a captured word identifies its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return {8'hAC, a[23:0]};
  endfunction

  assign InstrData = mem_word(InstrAddr);

  // Driver tasks
  task automatic clear_inputs();
    Stall        = 1'b0;
    BranchTaken  = 1'b0;
    BranchTarget = 32'h0;
    JumpTaken    = 1'b0;
    JumpIndex    = 26'h0;
    JRegTaken    = 1'b0;
    JRegTarget   = 32'h0;
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    Rst_n = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    Rst_n = 1'b0;
    #2;
    n_checks++; if (InstrAddr !== 32'h0) begin n_errors++; $display("FAIL reset_pc: got %h expected %h", InstrAddr, 32'h0); end
    n_checks++; if (IfId_Instr !== 32'h0) begin n_errors++; $display("FAIL reset_instr: got %h expected %h", IfId_Instr, 32'h0); end
    n_checks++; if (IfId_Valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", IfId_Valid); end
    n_checks++; if (AddrErr !== 1'b0) begin n_errors++; $display("FAIL reset_addrerr: got %b expected 0", AddrErr); end
    n_checks++; if (FetchCount !== 4'd0 || RedirectCount !== 4'd0) begin n_errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", FetchCount, RedirectCount); end
  endtask

  task automatic test_fetch();
    do_reset();
    step(1);
    n_checks++; if (IfId_Instr !== 32'h2008_0005) begin n_errors++; $display("FAIL fetch_first_instr: got %h expected %h", IfId_Instr, 32'h2008_0005); end
    n_checks++; if (IfId_PCPlus4 !== 32'h4) begin n_errors++; $display("FAIL fetch_first_pc4: got %h expected %h", IfId_PCPlus4, 32'h4); end
    n_checks++; if (IfId_Valid !== 1'b1) begin n_errors++; $display("FAIL fetch_first_valid: got %b expected 1", IfId_Valid); end
    step(3);
    n_checks++; if (InstrAddr !== 32'h10) begin n_errors++; $display("FAIL fetch4_pc: got %h expected %h", InstrAddr, 32'h10); end
    n_checks++; if (FetchCount !== 4'd4) begin n_errors++; $display("FAIL fetch4_count: got %0d expected 4", FetchCount); end
    n_checks++; if (IfId_Instr !== 32'hAC00_000C || IfId_PCPlus4 !== 32'h10) begin n_errors++; $display("FAIL fetch4_ifid: got %h/%h expected %h/%h", IfId_Instr, IfId_PCPlus4, 32'hAC00_000C, 32'h10); end
  endtask

  task automatic test_stall();
    do_reset();
    step(2);
    Stall = 1'b1;
    step(3);
    n_checks++; if (InstrAddr !== 32'h8) begin n_errors++; $display("FAIL stall_pc: got %h expected %h", InstrAddr, 32'h8); end
    n_checks++; if (IfId_Instr !== 32'hAC00_0004 || IfId_PCPlus4 !== 32'h8 || IfId_Valid !== 1'b1) begin n_errors++; $display("FAIL stall_ifid: got %h/%h/%b expected %h/%h/1", IfId_Instr, IfId_PCPlus4, IfId_Valid, 32'hAC00_0004, 32'h8); end
    n_checks++; if (FetchCount !== 4'd2) begin n_errors++; $display("FAIL stall_count: got %0d expected 2", FetchCount); end
    Stall = 1'b0;
    step(1);
    n_checks++; if (InstrAddr !== 32'hC || IfId_PCPlus4 !== 32'hC || IfId_Instr !== 32'hAC00_0008) begin n_errors++; $display("FAIL stall_resume: got %h/%h/%h expected %h/%h/%h", InstrAddr, IfId_PCPlus4, IfId_Instr, 32'hC, 32'hC, 32'hAC00_0008); end
    n_checks++; if (FetchCount !== 4'd3) begin n_errors++; $display("FAIL stall_resume_count: got %0d expected 3", FetchCount); end
  endtask

  task automatic test_jump();
    do_reset();
    // A branch places a word at 0x4000000C so the next fetch leaves
    // IfId_PCPlus4 = 0x40000010; that redirect is counted as well.
    BranchTaken = 1'b1; BranchTarget = 32'h4000_000C;
    step(1);
    clear_inputs();
    step(1);
    n_checks++; if (IfId_PCPlus4 !== 32'h4000_0010) begin n_errors++; $display("FAIL jump_setup_pc4: got %h expected %h", IfId_PCPlus4, 32'h4000_0010); end
    JumpTaken = 1'b1; JumpIndex = 26'h000_0100;
    step(1);
    clear_inputs();
    n_checks++; if (InstrAddr !== 32'h4000_0400) begin n_errors++; $display("FAIL jump_pc: got %h expected %h", InstrAddr, 32'h4000_0400); end
    n_checks++; if (IfId_Instr !== 32'h0 || IfId_Valid !== 1'b0 || IfId_PCPlus4 !== 32'h0) begin n_errors++; $display("FAIL jump_flush: got %h/%b/%h expected 0/0/0", IfId_Instr, IfId_Valid, IfId_PCPlus4); end
    n_checks++; if (RedirectCount !== 4'd2 || FetchCount !== 4'd1) begin n_errors++; $display("FAIL jump_counts: got %0d/%0d expected 2/1", RedirectCount, FetchCount); end
    step(1);
    n_checks++; if (IfId_Instr !== 32'hAC00_0400 || IfId_PCPlus4 !== 32'h4000_0404) begin n_errors++; $display("FAIL jump_target_fetch: got %h/%h expected %h/%h", IfId_Instr, IfId_PCPlus4, 32'hAC00_0400, 32'h4000_0404); end
  endtask

  // Continues from test_jump: RedirectCount=2, FetchCount=2.
  task automatic test_branch_priority();
    BranchTaken = 1'b1; BranchTarget = 32'h80;
    JumpTaken = 1'b1; JumpIndex = 26'h3FF_FFFF;
    JRegTaken = 1'b1; JRegTarget = 32'h200;
    Stall = 1'b1;
    step(1);
    clear_inputs();
    n_checks++; if (InstrAddr !== 32'h80) begin n_errors++; $display("FAIL prio_pc: got %h expected %h", InstrAddr, 32'h80); end
    n_checks++; if (IfId_Valid !== 1'b0 || IfId_Instr !== 32'h0) begin n_errors++; $display("FAIL prio_flush: got %b/%h expected 0/0", IfId_Valid, IfId_Instr); end
    n_checks++; if (RedirectCount !== 4'd3 || FetchCount !== 4'd2) begin n_errors++; $display("FAIL prio_counts: got %0d/%0d expected 3/2", RedirectCount, FetchCount); end
    n_checks++; if (AddrErr !== 1'b0) begin n_errors++; $display("FAIL prio_addrerr: got %b expected 0", AddrErr); end
  endtask

  task automatic test_jreg_misalign();
    JRegTaken = 1'b1; JRegTarget = 32'h103;
    step(1);
    clear_inputs();
    n_checks++; if (InstrAddr !== 32'h100) begin n_errors++; $display("FAIL jreg_pc: got %h expected %h", InstrAddr, 32'h100); end
    n_checks++; if (AddrErr !== 1'b1) begin n_errors++; $display("FAIL jreg_addrerr: got %b expected 1", AddrErr); end
    step(3);
    BranchTaken = 1'b1; BranchTarget = 32'h40;
    step(1);
    clear_inputs();
    n_checks++; if (AddrErr !== 1'b1 || InstrAddr !== 32'h40) begin n_errors++; $display("FAIL addrerr_sticky: got %b/%h expected 1/%h", AddrErr, InstrAddr, 32'h40); end
    do_reset();
    n_checks++; if (AddrErr !== 1'b0) begin n_errors++; $display("FAIL addrerr_reset: got %b expected 0", AddrErr); end
  endtask

  task automatic test_wrap();
    do_reset();
    BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFC;
    step(1);
    clear_inputs();
    n_checks++; if (InstrAddr !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL wrap_setup: got %h expected %h", InstrAddr, 32'hFFFF_FFFC); end
    step(1);
    n_checks++; if (InstrAddr !== 32'h0 || IfId_PCPlus4 !== 32'h0) begin n_errors++; $display("FAIL wrap_pc: got %h/%h expected 0/0", InstrAddr, IfId_PCPlus4); end
    n_checks++; if (IfId_Valid !== 1'b1 || IfId_Instr !== 32'hACFF_FFFC) begin n_errors++; $display("FAIL wrap_ifid: got %b/%h expected 1/%h", IfId_Valid, IfId_Instr, 32'hACFF_FFFC); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    step(17);
    n_checks++; if (FetchCount !== 4'd1) begin n_errors++; $display("FAIL fetch_count_wrap: got %0d expected 1", FetchCount); end
    BranchTaken = 1'b1; BranchTarget = 32'h40;
    step(17);
    clear_inputs();
    n_checks++; if (RedirectCount !== 4'd1 || FetchCount !== 4'd1) begin n_errors++; $display("FAIL redirect_count_wrap: got %0d/%0d expected 1/1", RedirectCount, FetchCount); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(2);
    Stall = 1'b1;
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    n_checks++; if (InstrAddr !== 32'h0 || IfId_PCPlus4 !== 32'h0 || IfId_Valid !== 1'b0) begin n_errors++; $display("FAIL async_reset_regs: got %h/%h/%b expected 0/0/0", InstrAddr, IfId_PCPlus4, IfId_Valid); end
    n_checks++; if (FetchCount !== 4'd0) begin n_errors++; $display("FAIL async_reset_count: got %0d expected 0", FetchCount); end
    Stall = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    step(1);
    n_checks++; if (IfId_Instr !== 32'h2008_0005 || IfId_PCPlus4 !== 32'h4) begin n_errors++; $display("FAIL async_reset_refetch: got %h/%h expected %h/%h", IfId_Instr, IfId_PCPlus4, 32'h2008_0005, 32'h4); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_jump();
    test_branch_priority();
    test_jreg_misalign();
    test_wrap();
    test_counter_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
